// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register carrying instruction word and PC+4 across a stage boundary.
// Two-entry skid buffer keeps in_ready purely registered; adds flush, NOP-on-empty and a stall counter.
module pipe_skid_reg #(
    parameter int          IR_W     = 32,
    parameter int          PC_W     = 32,
    parameter logic [31:0] RESET_PC = 32'h00003000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IR_W-1:0]  in_ir,
    input  logic [PC_W-1:0]  in_pc4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IR_W-1:0]  out_ir,
    output logic [PC_W-1:0]  out_pc4,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam logic [PC_W-1:0]  ResetPc = PC_W'(RESET_PC);
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [IR_W-1:0]   mainIr_q, mainIr_d;
    logic [PC_W-1:0]   mainPc4_q, mainPc4_d;
    logic [IR_W-1:0]   skidIr_q, skidIr_d;
    logic [PC_W-1:0]   skidPc4_q, skidPc4_d;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
    logic              inFire, outFire;

    // Handshake outputs come straight from the state flops, so no combinational ready path exists.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != TWO);
    assign occupancy = state_q;
    assign out_ir    = mainIr_q;
    assign out_pc4   = mainPc4_q;
    assign stall_cnt = stallCnt_q;

    assign inFire  = in_valid && in_ready;
    assign outFire = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        mainIr_d   = mainIr_q;
        mainPc4_d  = mainPc4_q;
        skidIr_d   = skidIr_q;
        skidPc4_d  = skidPc4_q;
        stallCnt_d = stallCnt_q;

        if (out_valid && !out_ready && (stallCnt_q != CntMax)) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end

        // Flush wins over both handshakes; main_ir returns to NOP while main_pc4 keeps its value.
        if (flush) begin
            state_d  = EMPTY;
            mainIr_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (inFire) begin
                        mainIr_d  = in_ir;
                        mainPc4_d = in_pc4;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (inFire && outFire) begin
                        mainIr_d  = in_ir;
                        mainPc4_d = in_pc4;
                    end else if (outFire) begin
                        mainIr_d = '0;
                        state_d  = EMPTY;
                    end else if (inFire) begin
                        skidIr_d  = in_ir;
                        skidPc4_d = in_pc4;
                        state_d   = TWO;
                    end
                end
                TWO: begin
                    if (outFire) begin
                        mainIr_d  = skidIr_q;
                        mainPc4_d = skidPc4_q;
                        state_d   = ONE;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    mainIr_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            mainIr_q   <= '0;
            mainPc4_q  <= ResetPc;
            skidIr_q   <= '0;
            skidPc4_q  <= '0;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mainIr_q   <= mainIr_d;
            mainPc4_q  <= mainPc4_d;
            skidIr_q   <= skidIr_d;
            skidPc4_q  <= skidPc4_d;
            stallCnt_q <= stallCnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed and random steps checked against a FIFO-queue reference model.
// A second instance with a 4-bit counter shares the stimulus to exercise counter saturation.
module tb_pipe_skid_reg;

    localparam int IR_W  = 32;
    localparam int PC_W  = 32;
    localparam int CNT_W = 16;
    localparam int SAT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [IR_W-1:0]  in_ir;
    logic [PC_W-1:0]  in_pc4;
    logic             out_valid;
    logic             out_ready;
    logic [IR_W-1:0]  out_ir;
    logic [PC_W-1:0]  out_pc4;
    logic             flush;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    logic             satInReady;
    logic             satOutValid;
    logic [IR_W-1:0]  satOutIr;
    logic [PC_W-1:0]  satOutPc4;
    logic [1:0]       satOccupancy;
    logic [SAT_W-1:0] satStallCnt;

    pipe_skid_reg #(.IR_W(IR_W), .PC_W(PC_W), .RESET_PC(32'h00003000), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc4(in_pc4),
        .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_pc4(out_pc4),
        .flush(flush), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_skid_reg #(.IR_W(IR_W), .PC_W(PC_W), .RESET_PC(32'h00003000), .CNT_W(SAT_W)) dutSat (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(satInReady), .in_ir(in_ir), .in_pc4(in_pc4),
        .out_valid(satOutValid), .out_ready(out_ready), .out_ir(satOutIr), .out_pc4(satOutPc4),
        .flush(flush), .occupancy(satOccupancy), .stall_cnt(satStallCnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [PC_W-1:0] pc4;
    } entry_t;

    entry_t           modelQ[$];
    logic [PC_W-1:0]  modelPc4;
    logic [CNT_W-1:0] modelCnt;
    logic [SAT_W-1:0] modelSatCnt;
    int               checks = 0;
    int               errors = 0;

    task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [IR_W-1:0] expIr;
        expIr = (modelQ.size() > 0) ? modelQ[0].ir : '0;
        checkVal({tag, ".out_valid"}, 64'(out_valid), 64'(modelQ.size() > 0));
        checkVal({tag, ".in_ready"},  64'(in_ready),  64'(modelQ.size() < 2));
        checkVal({tag, ".occupancy"}, 64'(occupancy), 64'(modelQ.size()));
        checkVal({tag, ".out_ir"},    64'(out_ir),    64'(expIr));
        checkVal({tag, ".out_pc4"},   64'(out_pc4),   64'(modelPc4));
        checkVal({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(modelCnt));
        checkVal({tag, ".sat_cnt"},   64'(satStallCnt), 64'(modelSatCnt));
        checkVal({tag, ".sat_ir"},    64'(satOutIr),  64'(expIr));
    endtask

    // One clock of stimulus: drive, let the edge happen, advance the queue model, then compare.
    task automatic applyStimulus(input string tag, input logic v, input logic [IR_W-1:0] ir,
                                 input logic [PC_W-1:0] pc4, input logic ordy, input logic fl);
        bit     acceptOk;
        bit     holding;
        entry_t e;
        in_valid  = v;
        in_ir     = ir;
        in_pc4    = pc4;
        out_ready = ordy;
        flush     = fl;
        acceptOk  = (modelQ.size() < 2);
        holding   = (modelQ.size() > 0);
        @(posedge clk);
        if (holding && !ordy) begin
            if (modelCnt != {CNT_W{1'b1}})    modelCnt++;
            if (modelSatCnt != {SAT_W{1'b1}}) modelSatCnt++;
        end
        if (fl) begin
            modelQ.delete();
        end else begin
            if (holding && ordy) void'(modelQ.pop_front());
            if (v && acceptOk) begin
                e.ir  = ir;
                e.pc4 = pc4;
                modelQ.push_back(e);
            end
        end
        if (modelQ.size() > 0) modelPc4 = modelQ[0].pc4;
        #1;
        checkOutput(tag);
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        modelQ.delete();
        modelPc4    = 32'h00003000;
        modelCnt    = '0;
        modelSatCnt = '0;
        checkOutput(tag);
        checkVal({tag, ".pc4_const"}, 64'(out_pc4), 64'h3000);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_ir     = '0;
        in_pc4    = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        modelPc4    = 32'h00003000;
        modelCnt    = '0;
        modelSatCnt = '0;
        repeat (2) @(posedge clk);
        doReset("reset0");

        for (int i = 0; i < 5; i++) begin
            applyStimulus("stream", 1'b1, 32'h11 + i, 32'h3004 + 4 * i, 1'b1, 1'b0);
            checkVal("stream.ir_const", 64'(out_ir), 64'(32'h11 + i));
            checkVal("stream.occ_const", 64'(occupancy), 64'd1);
        end
        applyStimulus("drain", 1'b0, '0, '0, 1'b1, 1'b0);

        applyStimulus("skidA", 1'b1, 32'hA, 32'h4000, 1'b0, 1'b0);
        applyStimulus("skidB", 1'b1, 32'hB, 32'h4004, 1'b0, 1'b0);
        checkVal("skidB.in_ready_const", 64'(in_ready), 64'd0);
        checkVal("skidB.head_const", 64'(out_ir), 64'hA);
        applyStimulus("skidC0", 1'b1, 32'hC, 32'h4008, 1'b0, 1'b0);
        applyStimulus("skidC1", 1'b1, 32'hC, 32'h4008, 1'b0, 1'b0);
        checkVal("skid.stall_const", 64'(stall_cnt), 64'd3);
        applyStimulus("relB", 1'b1, 32'hC, 32'h4008, 1'b1, 1'b0);
        checkVal("relB.head_const", 64'(out_ir), 64'hB);
        applyStimulus("relC", 1'b1, 32'hC, 32'h4008, 1'b1, 1'b0);
        checkVal("relC.head_const", 64'(out_ir), 64'hC);
        applyStimulus("relEnd", 1'b0, '0, '0, 1'b1, 1'b0);
        checkVal("relEnd.empty_ir", 64'(out_ir), 64'd0);

        applyStimulus("fillA", 1'b1, 32'h21, 32'h5000, 1'b0, 1'b0);
        applyStimulus("fillB", 1'b1, 32'h22, 32'h5004, 1'b0, 1'b0);
        applyStimulus("flushTwo", 1'b1, 32'h23, 32'h5008, 1'b0, 1'b1);
        checkVal("flushTwo.pc4_const", 64'(out_pc4), 64'h5000);
        applyStimulus("postFlush", 1'b0, '0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus("random", 1'($urandom_range(0, 1)), $urandom, $urandom,
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end

        applyStimulus("satLoad", 1'b1, 32'h31, 32'h6000, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus("satHold", 1'b0, '0, '0, 1'b0, 1'b0);
        end
        checkVal("sat.stop_const", 64'(satStallCnt), 64'd15);
        applyStimulus("satFlush", 1'b0, '0, '0, 1'b0, 1'b1);
        checkVal("sat.flush_const", 64'(satStallCnt), 64'd15);

        applyStimulus("midA", 1'b1, 32'h41, 32'h7000, 1'b0, 1'b0);
        applyStimulus("midB", 1'b1, 32'h42, 32'h7004, 1'b0, 1'b0);
        doReset("resetMid");
        checkVal("resetMid.sat_const", 64'(satStallCnt), 64'd0);
        applyStimulus("afterReset", 1'b1, 32'h51, 32'h8000, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised, elastic inter-stage pipeline register that carries the instruction word and PC+4 between pipeline stages. It uses a valid/ready handshake instead of a bare stall input. A two-entry skid buffer keeps `in_ready` a pure registered signal, which breaks the combinational stall path back to the fetch stage. The block also provides a flush that inserts a bubble, a NOP-on-empty output, and a saturating stall-cycle counter for performance monitoring. Intended placement: F→D, and reusable at any later stage boundary.

## Interface
- `IR_W`, default 32: instruction word width.
- `PC_W`, default 32: PC+4 field width.
- `RESET_PC`, default 32'h00003000: value of `out_pc4` after reset, truncated to `PC_W`.
- `CNT_W`, default 16: stall counter width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream presents an entry.
- `in_ready`  out  1  block can accept an entry; registered.
- `in_ir`  in  IR_W  instruction from upstream.
- `in_pc4`  in  PC_W  PC+4 from upstream.
- `out_valid`  out  1  `out_ir`/`out_pc4` hold a live entry.
- `out_ready`  in  1  downstream accepts; low = downstream stall.
- `out_ir`  out  IR_W  head-entry instruction; 0 (NOP) when empty.
- `out_pc4`  out  PC_W  head-entry PC+4; holds its last value when empty.
- `flush`  in  1  discard all held entries this edge.
- `occupancy`  out  2  entries held (0..2).
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`; saturating.

## Operation
- Storage: a main register (drives the outputs) and a skid register. State is encoded as EMPTY(0), ONE(1), TWO(2), and `occupancy` is the state encoding.
- Handshake events:
  - `in_fire = in_valid && in_ready`.
  - `out_fire = out_valid && out_ready`.
- Output decode: `out_valid = (state != EMPTY)`; `in_ready = (state != TWO)`, decoded from state flops only.
- Transitions when flush=0:
  - EMPTY: on `in_fire`, main ← in, go to ONE; otherwise stay.
  - ONE, `in_fire && out_fire`: main ← in, stay ONE.
  - ONE, `out_fire` only: go to EMPTY, main_ir ← 0.
  - ONE, `in_fire` only: skid ← in, go to TWO.
  - ONE, neither: hold.
  - TWO, `out_fire`: main ← skid, go to ONE. No input is accepted in TWO.
  - TWO, no `out_fire`: hold.
- Flush:
  - Takes priority over all handshakes: next state EMPTY, main_ir ← 0, skid contents become don't-care, main_pc4 unchanged.
  - An `in_fire` or `out_fire` in the flush cycle is dropped. Upstream must not count that input as delivered; downstream may consume the output presented that cycle.
- Order is preserved: entries leave in arrival order, never duplicated, never lost except by flush.
- stall_cnt: +1 on every edge where `out_valid && !out_ready`; sticks at 2^CNT_W−1. Cleared only by reset; flush does not clear it.
- No X-propagation: `out_ir` is always 0 or a captured `in_ir`.

## Timing
- Reset (asynchronous, immediate) sets:
  - state EMPTY, so `out_valid=0`, `in_ready=1`, `occupancy=0`;
  - `out_ir=0`, `out_pc4=RESET_PC`, `stall_cnt=0`.
- Reset asserted mid-operation discards both entries at once, independent of `clk`.
- Latency: an accepted input appears on `out_*` at the next edge when state is EMPTY, or when state is ONE with `out_fire` in the same cycle. Otherwise it waits behind the queued entries.
- Throughput: one entry per cycle while `out_ready=1`.
- `in_ready` falls one cycle after the edge that entered TWO. It rises on the edge after `out_fire` in TWO.
- Flush effect is visible one edge later: `out_valid=0` and `in_ready=1` in the following cycle.

## Test plan
- Reset: assert `reset` between edges → outputs change immediately to `out_valid=0`, `in_ready=1`, `out_ir=0`, `out_pc4=0x3000`, `stall_cnt=0`.
- Streaming: `out_ready=1`, feed IR 0x11..0x15 with PC4 0x3004..0x3014 back to back → each appears exactly one cycle later, `occupancy` stays 1, `in_ready` stays 1.
- Backpressure/skid: hold `out_ready=0` while sending A, B, C →
  - A is on the outputs and B is in skid;
  - `in_ready=0` from the cycle after B is accepted, so C is held upstream;
  - `stall_cnt` counts each blocked cycle;
  - after `out_ready=1`, outputs are A, B, C in order with no loss.
- Simultaneous fire in ONE: `in_fire` and `out_fire` on the same edge → the new entry replaces the head, `occupancy` stays 1.
- Flush in TWO with `in_valid=1` → next cycle `out_valid=0`, `out_ir=0`, `out_pc4` unchanged, `occupancy=0`, `in_ready=1`; the flush-cycle input is not captured.
- Saturation with `CNT_W=4`: hold a stalled state for 20 cycles → `stall_cnt` stops at 15; a flush leaves it at 15; reset returns it to 0.
